rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter_pkg.sv | 31 +++
 rtl/rom_arb_priority.sv | 44 ++++
 rtl/rom_arbiter.sv | 84 ++++++++
 tb/tb_rom_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arbiter_pkg.sv
// Shared types for the ROM arbiter: data word, ROM byte address, word-offset
// size and the arbiter response state encoding.
`ifndef ROM_ARBITER_PKG_SV
`define ROM_ARBITER_PKG_SV

// Word index of a byte address.
`define WORD_ADDRESS(addr) ((addr) >> rom_arbiter_pkg::WORD_ADDRESS_SIZE)

package rom_arbiter_pkg;

    localparam int unsigned WORD_WIDTH        = 32;
    localparam int unsigned ROM_ADDRESS_WIDTH = 12;
    localparam int unsigned WORD_ADDRESS_SIZE = 2;

    typedef logic [WORD_WIDTH-1:0]        Word;
    typedef logic [ROM_ADDRESS_WIDTH-1:0] RomAddress;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_IF = 2'd1,
        RESP_LS = 2'd2
    } RomArbState;

    // True when the byte address is not word aligned.
    function automatic logic is_misaligned(RomAddress addr);
        return addr[WORD_ADDRESS_SIZE-1:0] != '0;
    endfunction

endpackage

`endif

// File: rtl/rom_arb_priority.sv
// Fetch vs load/store priority select. Load/store normally wins; after
// STREAK_MAX consecutive contended load/store grants, fetch is forced through.
module rom_arb_priority
    import rom_arbiter_pkg::*;
#(
    parameter int unsigned STREAK_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic ls_req,
    output logic if_sel,
    output logic ls_sel
);

    localparam int unsigned STREAK_WIDTH = $clog2(STREAK_MAX + 1);

    logic [STREAK_WIDTH-1:0] streak_q, streak_d;
    logic                    streak_full;

    // Grant select and next streak count.
    always_comb begin
        streak_full = (streak_q == STREAK_WIDTH'(STREAK_MAX));
        ls_sel      = ls_req && !(if_req && streak_full);
        if_sel      = if_req && !ls_sel;
        streak_d    = streak_q;
        // Streak only counts cycles where fetch was actually kept waiting.
        if (!if_req || if_sel) begin
            streak_d = '0;
        end else if (ls_sel && !streak_full) begin
            streak_d = streak_q + 1'b1;
        end
    end

    // Streak register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a single combinational ROM read port.
// Grants are combinational; responses come exactly one cycle after the grant.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int unsigned STREAK_MAX = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      if_req,
    input  RomAddress if_addr,
    output logic      if_gnt,
    output logic      if_rvalid,
    output Word       if_rdata,
    output logic      if_err,
    input  logic      ls_req,
    input  RomAddress ls_addr,
    output logic      ls_gnt,
    output logic      ls_rvalid,
    output Word       ls_rdata,
    output logic      ls_err,
    output RomAddress rom_address,
    input  Word       rom_out
);

    RomArbState state;
    logic       rom_mis;

    rom_arb_priority #(
        .STREAK_MAX(STREAK_MAX)
    ) u_priority (
        .clk   (clk),
        .rst_n (rst_n),
        .if_req(if_req),
        .ls_req(ls_req),
        .if_sel(if_gnt),
        .ls_sel(ls_gnt)
    );

    // ROM address follows the granted port, zero when idle.
    always_comb begin
        rom_address = '0;
        if (if_gnt) begin
            rom_address = if_addr;
        end else if (ls_gnt) begin
            rom_address = ls_addr;
        end
        rom_mis = is_misaligned(rom_address);
    end

    // Response FSM: captures ROM data at the grant edge, registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            if_rdata <= '0;
            if_err   <= 1'b0;
            ls_rdata <= '0;
            ls_err   <= 1'b0;
        end else begin
            if_rdata <= '0;
            if_err   <= 1'b0;
            ls_rdata <= '0;
            ls_err   <= 1'b0;
            if (if_gnt) begin
                state    <= RESP_IF;
                if_err   <= rom_mis;
                if_rdata <= rom_mis ? '0 : rom_out;
            end else if (ls_gnt) begin
                state    <= RESP_LS;
                ls_err   <= rom_mis;
                ls_rdata <= rom_mis ? '0 : rom_out;
            end else begin
                state <= IDLE;
            end
        end
    end

    // Valid strobes decoded from the response state.
    always_comb begin
        if_rvalid = (state == RESP_IF);
        ls_rvalid = (state == RESP_LS);
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: vector table with a response
// scoreboard, plus hand-written reset sequences.
module tb_rom_arbiter;
    import rom_arbiter_pkg::*;

    logic      clk;
    logic      rst_n;
    logic      if_req, ls_req;
    RomAddress if_addr, ls_addr, rom_address;
    logic      if_gnt, if_rvalid, if_err;
    logic      ls_gnt, ls_rvalid, ls_err;
    Word       if_rdata, ls_rdata, rom_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic      ir;
        RomAddress ia;
        logic      lr;
        RomAddress la;
        logic      gi;
        logic      gl;
    } vec_t;

    typedef struct {
        logic vi;
        Word  di;
        logic ei;
        logic vl;
        Word  dl;
        logic el;
    } resp_t;

    vec_t  vecs[$];
    resp_t sb[$];

    // ROM model: word n holds 0xC0DE0000 | n.
    function automatic Word rom_word(RomAddress a);
        return 32'hC0DE_0000 | 32'(a >> 2);
    endfunction

    assign rom_out = rom_word(rom_address);

    rom_arbiter #(
        .STREAK_MAX(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .if_err     (if_err),
        .ls_req     (ls_req),
        .ls_addr    (ls_addr),
        .ls_gnt     (ls_gnt),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .ls_err     (ls_err),
        .rom_address(rom_address),
        .rom_out    (rom_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic add(input logic ir, input RomAddress ia, input logic lr, input RomAddress la,
                       input logic gi, input logic gl);
        vec_t v;
        v.ir = ir; v.ia = ia; v.lr = lr; v.la = la; v.gi = gi; v.gl = gl;
        vecs.push_back(v);
    endtask

    function automatic resp_t idle_resp();
        resp_t r;
        r.vi = 1'b0; r.di = '0; r.ei = 1'b0;
        r.vl = 1'b0; r.dl = '0; r.el = 1'b0;
        return r;
    endfunction

    // Applies one vector at a negedge; checks grants now and last cycle's response.
    task automatic step(input int idx, input vec_t v);
        resp_t     e;
        RomAddress want_addr;
        if_req  = v.ir;
        if_addr = v.ia;
        ls_req  = v.lr;
        ls_addr = v.la;
        #1;
        want_addr = v.gi ? v.ia : (v.gl ? v.la : '0);
        chk($sformatf("v%0d if_gnt", idx), 32'(if_gnt), 32'(v.gi));
        chk($sformatf("v%0d ls_gnt", idx), 32'(ls_gnt), 32'(v.gl));
        chk($sformatf("v%0d rom_address", idx), 32'(rom_address), 32'(want_addr));
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL v%0d scoreboard: got empty want entry", idx);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d if_rvalid", idx), 32'(if_rvalid), 32'(e.vi));
            chk($sformatf("v%0d if_rdata", idx), if_rdata, e.di);
            chk($sformatf("v%0d if_err", idx), 32'(if_err), 32'(e.ei));
            chk($sformatf("v%0d ls_rvalid", idx), 32'(ls_rvalid), 32'(e.vl));
            chk($sformatf("v%0d ls_rdata", idx), ls_rdata, e.dl);
            chk($sformatf("v%0d ls_err", idx), 32'(ls_err), 32'(e.el));
        end
        e = idle_resp();
        if (v.gi) begin
            e.vi = 1'b1;
            e.ei = (v.ia[1:0] != 2'b00);
            e.di = e.ei ? 32'h0 : rom_word(v.ia);
        end else if (v.gl) begin
            e.vl = 1'b1;
            e.el = (v.la[1:0] != 2'b00);
            e.dl = e.el ? 32'h0 : rom_word(v.la);
        end
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        if_req  = 1'b0;
        ls_req  = 1'b0;
        if_addr = '0;
        ls_addr = '0;

        // Vector table: if_req, if_addr, ls_req, ls_addr, expected if_gnt, ls_gnt.
        add(0, 12'h000, 0, 12'h000, 0, 0);
        add(1, 12'h008, 0, 12'h000, 1, 0);
        add(0, 12'h000, 0, 12'h000, 0, 0);
        add(0, 12'h000, 1, 12'h006, 0, 1);
        add(0, 12'h000, 1, 12'h01C, 0, 1);
        add(1, 12'h005, 0, 12'h000, 1, 0);
        for (int k = 0; k < 4; k++) add(1, RomAddress'(4 * k), 0, 12'h000, 1, 0);
        add(0, 12'h000, 0, 12'h000, 0, 0);
        // Contended for 7 cycles: ls x4, forced if, then ls again.
        for (int k = 0; k < 7; k++) add(1, 12'h010, 1, 12'h020, k == 4, k != 4);
        add(0, 12'h000, 0, 12'h000, 0, 0);
        // A cycle with if_req low clears the streak.
        for (int k = 0; k < 2; k++) add(1, 12'h010, 1, 12'h020, 0, 1);
        add(0, 12'h000, 1, 12'h024, 0, 1);
        for (int k = 0; k < 5; k++) add(1, 12'h010, 1, 12'h020, k == 4, k != 4);
        add(0, 12'h000, 0, 12'h000, 0, 0);
        // An uncontended fetch grant clears the streak.
        for (int k = 0; k < 3; k++) add(1, 12'h010, 1, 12'h020, 0, 1);
        add(1, 12'h010, 0, 12'h000, 1, 0);
        for (int k = 0; k < 5; k++) add(1, 12'h014, 1, 12'h028, k == 4, k != 4);
        add(0, 12'h000, 0, 12'h000, 0, 0);

        // Reset state.
        #2;
        chk("reset if_rvalid", 32'(if_rvalid), 32'h0);
        chk("reset ls_rvalid", 32'(ls_rvalid), 32'h0);
        chk("reset if_rdata", if_rdata, 32'h0);
        chk("reset ls_err", 32'(ls_err), 32'h0);
        chk("reset rom_address", 32'(rom_address), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(idle_resp());

        foreach (vecs[i]) step(i, vecs[i]);

        // Reset during a grant cycle: grant visible, no response afterwards.
        if_req  = 1'b0;
        ls_req  = 1'b0;
        rst_n   = 1'b0;
        if_req  = 1'b1;
        if_addr = 12'h004;
        #1;
        chk("rst grant if_gnt", 32'(if_gnt), 32'h1);
        chk("rst grant rom_address", 32'(rom_address), 32'h4);
        @(posedge clk);
        #1;
        chk("rst grant if_rvalid", 32'(if_rvalid), 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        if_req = 1'b0;
        @(posedge clk);
        #1;
        chk("post rst if_rvalid", 32'(if_rvalid), 32'h0);
        chk("post rst ls_rvalid", 32'(ls_rvalid), 32'h0);

        // Reset during a response cycle drops rvalid at once.
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 12'h008;
        @(negedge clk);
        if_req = 1'b0;
        #1;
        chk("resp if_rvalid", 32'(if_rvalid), 32'h1);
        chk("resp if_rdata", if_rdata, 32'hC0DE_0002);
        rst_n = 1'b0;
        #1;
        chk("resp rst if_rvalid", 32'(if_rvalid), 32'h0);
        chk("resp rst if_rdata", if_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("idle%0d if_rvalid", k), 32'(if_rvalid), 32'h0);
            chk($sformatf("idle%0d ls_rvalid", k), 32'(ls_rvalid), 32'h0);
        end

        // Streak starts from zero after reset: contended request goes to ls.
        @(negedge clk);
        if_req  = 1'b1;
        ls_req  = 1'b1;
        if_addr = 12'h000;
        ls_addr = 12'h00C;
        #1;
        chk("after rst ls_gnt", 32'(ls_gnt), 32'h1);
        @(posedge clk);
        #1;
        chk("after rst ls_rdata", ls_rdata, 32'hC0DE_0003);
        if_req = 1'b0;
        ls_req = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
